// File: rtl/benes_pkg.sv
// Shared sizing, stage-row type and controller state encoding for the Benes
// network schedule controller.
package benes_pkg;

  localparam int N_PORTS    = 8;
  localparam int LOG2_N     = $clog2(N_PORTS);
  localparam int STAGES     = 2 * LOG2_N - 1;
  localparam int SW_PER_STG = N_PORTS / 2;
  localparam int NUM_CFG    = 4;
  localparam int CFG_AW     = $clog2(NUM_CFG);
  localparam int STG_AW     = $clog2(STAGES);

  typedef logic [SW_PER_STG-1:0] stage_row_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CFG   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/benes_cfg_table.sv
// Permutation configuration table: one write port, one read port per stage.
// Each stage reads only its own row of the entry selected for that stage.
module benes_cfg_table
  import benes_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [CFG_AW-1:0]            wr_addr,
  input  logic [STG_AW-1:0]            wr_stage,
  input  stage_row_t                   wr_data,
  input  logic [STAGES*CFG_AW-1:0]     rd_addr,
  output logic [STAGES*SW_PER_STG-1:0] rd_data
);

  stage_row_t mem [NUM_CFG][STAGES];

  // Stage indices with no matching row (>= STAGES) simply never hit a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < NUM_CFG; a++) begin
        for (int s = 0; s < STAGES; s++) begin
          mem[a][s] <= '0;
        end
      end
    end else begin
      for (int a = 0; a < NUM_CFG; a++) begin
        for (int s = 0; s < STAGES; s++) begin
          if (we && (wr_addr == CFG_AW'(a)) && (wr_stage == STG_AW'(s))) begin
            mem[a][s] <= wr_data;
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_rd
      assign rd_data[gi*SW_PER_STG +: SW_PER_STG] = mem[rd_addr[gi*CFG_AW +: CFG_AW]][gi];
    end
  endgenerate

endmodule

// File: rtl/benes_sched_ctrl.sv
// Schedule controller for a pipelined Benes fabric: skews per-beat switch
// settings across stages and arbitrates exclusive table-write windows.
module benes_sched_ctrl
  import benes_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_req,
  output logic                         cfg_gnt,
  input  logic                         cfg_we,
  input  logic [CFG_AW-1:0]            cfg_addr,
  input  logic [STG_AW-1:0]            cfg_stage,
  input  logic [SW_PER_STG-1:0]        cfg_bits,
  input  logic                         in_valid,
  input  logic [CFG_AW-1:0]            in_sel,
  output logic                         in_ready,
  output logic [STAGES*SW_PER_STG-1:0] sw_set,
  output logic                         out_valid,
  output logic                         busy
);

  ctrl_state_e state_reg, state_next;

  logic                         accept;
  logic [STAGES:1]              vld_reg;
  logic [CFG_AW-1:0]            sel_reg [1:STAGES-1];
  logic [STAGES-1:0]            row_vld;
  logic [STAGES*CFG_AW-1:0]     row_sel;
  logic [STAGES*SW_PER_STG-1:0] tbl_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      RUN:     if (cfg_req) state_next = DRAIN;
      DRAIN:   if (!busy) state_next = CFG;
      CFG:     if (!cfg_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Ready is withheld the cycle a request appears and while reset is held.
  assign in_ready = (state_reg == RUN) && !cfg_req && !rst;
  assign cfg_gnt  = (state_reg == CFG);
  assign accept   = in_valid && in_ready;

  // Stage 0 uses the incoming beat directly; stage s uses the beat accepted s cycles ago.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_reg <= '0;
      for (int s = 1; s < STAGES; s++) begin
        sel_reg[s] <= '0;
      end
    end else begin
      vld_reg    <= {vld_reg[STAGES-1:1], accept};
      sel_reg[1] <= in_sel;
      for (int s = 2; s < STAGES; s++) begin
        sel_reg[s] <= sel_reg[s-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_row
      if (gi == 0) begin : g_head
        assign row_vld[gi]                   = accept;
        assign row_sel[gi*CFG_AW +: CFG_AW]  = in_sel;
      end else begin : g_tail
        assign row_vld[gi]                   = vld_reg[gi];
        assign row_sel[gi*CFG_AW +: CFG_AW]  = sel_reg[gi];
      end
      assign sw_set[gi*SW_PER_STG +: SW_PER_STG] =
        row_vld[gi] ? tbl_data[gi*SW_PER_STG +: SW_PER_STG] : '0;
    end
  endgenerate

  assign out_valid = vld_reg[STAGES];
  assign busy      = |vld_reg;

  benes_cfg_table u_table (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_gnt && cfg_we),
    .wr_addr  (cfg_addr),
    .wr_stage (cfg_stage),
    .wr_data  (cfg_bits),
    .rd_addr  (row_sel),
    .rd_data  (tbl_data)
  );

endmodule

// File: tb/tb_benes_sched_ctrl.sv
// Directed self-checking bench for benes_sched_ctrl.
module tb_benes_sched_ctrl;
  import benes_pkg::*;

  localparam int SWW = STAGES * SW_PER_STG;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_req;
  logic              cfg_gnt;
  logic              cfg_we;
  logic [CFG_AW-1:0] cfg_addr;
  logic [STG_AW-1:0] cfg_stage;
  logic [SW_PER_STG-1:0] cfg_bits;
  logic              in_valid;
  logic [CFG_AW-1:0] in_sel;
  logic              in_ready;
  logic [SWW-1:0]    sw_set;
  logic              out_valid;
  logic              busy;

  stage_row_t tbl [NUM_CFG][STAGES];
  int checks   = 0;
  int failures = 0;

  benes_sched_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_req   (cfg_req),
    .cfg_gnt   (cfg_gnt),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_stage (cfg_stage),
    .cfg_bits  (cfg_bits),
    .in_valid  (in_valid),
    .in_sel    (in_sel),
    .in_ready  (in_ready),
    .sw_set    (sw_set),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SWW-1:0] row_only(input int s, input stage_row_t v);
    logic [SWW-1:0] r;
    r = '0;
    if (s >= 0 && s < STAGES) r[s*SW_PER_STG +: SW_PER_STG] = v;
    return r;
  endfunction

  task automatic cfg_open(output int waited);
    bit got;
    got = 1'b0;
    waited = 0;
    cfg_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cfg_gnt) begin
        got = 1'b1;
        waited = i;
        break;
      end
      tick();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL cfg_open_timeout got cfg_gnt=%b want 1 within 30 cycles", cfg_gnt);
    end
  endtask

  task automatic cfg_write(input int a, input int s, input stage_row_t bits);
    cfg_we    = 1'b1;
    cfg_addr  = CFG_AW'(a);
    cfg_stage = STG_AW'(s);
    cfg_bits  = bits;
    tick();
    cfg_we = 1'b0;
    if (s < STAGES) tbl[a][s] = bits;
    $display("cfg write addr=%0d stage=%0d bits=%h", a, s, bits);
  endtask

  task automatic cfg_close();
    cfg_req = 1'b0;
    cfg_we  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (sw_set !== '0 || out_valid !== 1'b0 || cfg_gnt !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got sw_set=%h out_valid=%b cfg_gnt=%b busy=%b want all 0",
               sw_set, out_valid, cfg_gnt, busy);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    $display("reset done in_ready=%b", in_ready);
    tick();
  endtask

  task automatic test_identity();
    in_valid = 1'b1;
    in_sel   = '0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (sw_set !== '0 || out_valid !== (k == STAGES) || busy !== (k >= 1 && k <= STAGES)) begin
        failures++;
        $display("FAIL identity_k%0d got sw_set=%h out_valid=%b busy=%b want 0/%b/%b",
                 k, sw_set, out_valid, busy, (k == STAGES), (k >= 1 && k <= STAGES));
      end
      $display("identity k=%0d sw_set=%h out_valid=%b", k, sw_set, out_valid);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic test_single_entry();
    int w;
    cfg_open(w);
    checks++;
    if (w !== 2) begin
      failures++;
      $display("FAIL empty_pipe_gnt_latency got %0d want 2", w);
    end
    cfg_write(1, 0, 4'hF);
    cfg_write(1, 1, 4'h0);
    cfg_write(1, 2, 4'hA);
    cfg_write(1, 3, 4'h0);
    cfg_write(1, 4, 4'h5);
    cfg_write(2, 0, 4'h3);
    cfg_write(2, 1, 4'hC);
    cfg_write(2, 2, 4'h6);
    cfg_write(2, 3, 4'h9);
    cfg_write(2, 4, 4'h1);
    cfg_close();
    in_valid = 1'b1;
    in_sel   = 2'd1;
    for (int k = 0; k <= STAGES; k++) begin
      logic [SWW-1:0] exp;
      exp = '0;
      if (k < STAGES) exp = row_only(k, tbl[1][k]);
      @(negedge clk);
      checks++;
      if (sw_set !== exp || out_valid !== (k == STAGES)) begin
        failures++;
        $display("FAIL entry1_k%0d got sw_set=%h out_valid=%b want %h/%b",
                 k, sw_set, out_valid, exp, (k == STAGES));
      end
      $display("entry1 k=%0d sw_set=%h", k, sw_set);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int seq [4];
    seq = '{1, 2, 1, 2};
    for (int k = 0; k <= 9; k++) begin
      logic [SWW-1:0] exp;
      in_valid = (k < 4);
      if (k < 4) in_sel = CFG_AW'(seq[k]);
      exp = '0;
      for (int s = 0; s < STAGES; s++) begin
        int j;
        j = k - s;
        if (j >= 0 && j < 4) exp[s*SW_PER_STG +: SW_PER_STG] = tbl[seq[j]][s];
      end
      @(negedge clk);
      checks++;
      if (sw_set !== exp || out_valid !== (k >= STAGES && k <= STAGES + 3)) begin
        failures++;
        $display("FAIL b2b_k%0d got sw_set=%h out_valid=%b want %h/%b",
                 k, sw_set, out_valid, exp, (k >= STAGES && k <= STAGES + 3));
      end
      $display("b2b k=%0d sw_set=%h out_valid=%b", k, sw_set, out_valid);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_cfg_drain();
    for (int k = 0; k <= 10; k++) begin
      in_valid  = (k <= 3);
      in_sel    = 2'd1;
      cfg_req   = (k >= 3);
      cfg_we    = (k >= 3 && k <= 7);
      cfg_addr  = 2'd3;
      cfg_stage = '0;
      cfg_bits  = 4'hF;
      @(negedge clk);
      checks++;
      if (in_ready !== (k < 3) || busy !== (k >= 1 && k <= 7) ||
          cfg_gnt !== (k >= 9) || out_valid !== (k >= 5 && k <= 7)) begin
        failures++;
        $display("FAIL drain_k%0d got in_ready=%b busy=%b cfg_gnt=%b out_valid=%b want %b/%b/%b/%b",
                 k, in_ready, busy, cfg_gnt, out_valid,
                 (k < 3), (k >= 1 && k <= 7), (k >= 9), (k >= 5 && k <= 7));
      end
      if (k == 3) begin
        checks++;
        if (sw_set[SW_PER_STG-1:0] !== '0) begin
          failures++;
          $display("FAIL drain_no_accept got row0=%h want 0", sw_set[SW_PER_STG-1:0]);
        end
      end
      $display("drain k=%0d in_ready=%b busy=%b cfg_gnt=%b", k, in_ready, busy, cfg_gnt);
      tick();
    end
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    cfg_close();
    in_valid = 1'b1;
    in_sel   = 2'd3;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || sw_set !== '0) begin
      failures++;
      $display("FAIL early_we_ignored got in_ready=%b sw_set=%h want 1/0", in_ready, sw_set);
    end
    $display("after drain sel=3 sw_set=%h", sw_set);
    tick();
    in_valid = 1'b0;
    repeat (STAGES + 1) tick();
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_sel   = 2'd1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      tick();
    end
    #2;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got out_valid=%b busy=%b want 1/1", out_valid, busy);
    end
    rst = 1'b1;
    for (int a = 0; a < NUM_CFG; a++)
      for (int s = 0; s < STAGES; s++) tbl[a][s] = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sw_set !== '0) begin
      failures++;
      $display("FAIL async_reset got out_valid=%b busy=%b sw_set=%h want 0/0/0",
               out_valid, busy, sw_set);
    end
    $display("mid-stream reset out_valid=%b busy=%b sw_set=%h", out_valid, busy, sw_set);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_ready got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b1;
    in_sel   = 2'd1;
    for (int k = 0; k <= STAGES; k++) begin
      @(negedge clk);
      checks++;
      if (sw_set !== '0 || out_valid !== (k == STAGES)) begin
        failures++;
        $display("FAIL post_reset_table_k%0d got sw_set=%h out_valid=%b want 0/%b",
                 k, sw_set, out_valid, (k == STAGES));
      end
      $display("post reset k=%0d sw_set=%h", k, sw_set);
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic test_bad_stage();
    int w;
    cfg_open(w);
    cfg_write(2, 7, 4'hF);
    cfg_write(2, 4, 4'h6);
    cfg_close();
    in_valid = 1'b1;
    in_sel   = 2'd2;
    for (int k = 0; k <= STAGES; k++) begin
      logic [SWW-1:0] exp;
      exp = '0;
      if (k < STAGES) exp = row_only(k, tbl[2][k]);
      @(negedge clk);
      checks++;
      if (sw_set !== exp) begin
        failures++;
        $display("FAIL bad_stage_k%0d got sw_set=%h want %h", k, sw_set, exp);
      end
      $display("bad stage k=%0d sw_set=%h", k, sw_set);
      tick();
      in_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    cfg_req   = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_stage = '0;
    cfg_bits  = '0;
    in_valid  = 1'b0;
    in_sel    = '0;
    for (int a = 0; a < NUM_CFG; a++)
      for (int s = 0; s < STAGES; s++) tbl[a][s] = '0;
    test_reset();
    test_identity();
    test_single_entry();
    test_back_to_back();
    test_cfg_drain();
    test_reset_mid();
    test_bad_stage();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
